// File: rtl/mem_port_arbiter_pkg.sv
// Shared types, width defaults and helpers for the memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned ARB_ADDR_W = 9;
  localparam int unsigned ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_IF = 2'd1,
    ARB_BUSY_D  = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_t;

  // Width needed to hold values 0..max_val; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline/memory side bundle of the memory port arbiter.
// slave: seen from the arbiter; master: seen from pipeline and memory.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ARB_ADDR_W,
  parameter int unsigned DATA_W = ARB_DATA_W
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_if;
  logic              stall_mem;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_valid, d_rdata, d_valid,
           mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_valid, d_rdata, d_valid,
           mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );

endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// arb_lat_counter: loadable down counter with saturating decrement and zero flag.
// Used for access latency and for the fetch starvation budget.
module arb_lat_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_VAL = 2,
  parameter int unsigned RST_VAL = 0,
  localparam int unsigned CNT_W  = cnt_w(MAX_VAL)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CNT_W'(RST_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port fixed-latency memory between fetch and data ports.
// Optional fetch starvation guard: define ARB_FAIRNESS_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ARB_ADDR_W,
  parameter int unsigned DATA_W     = ARB_DATA_W,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  // state       | meaning
  // ARB_IDLE    | nothing in flight, arbitrates every cycle
  // ARB_BUSY_IF | fetch issued, waiting for latency to expire
  // ARB_BUSY_D  | data access issued, waiting for latency to expire

  localparam int unsigned LAT_W = cnt_w(MEM_LAT);

  arb_state_t        state_q;
  logic              d_we_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              if_valid_q;
  logic              d_valid_q;

  logic   gnt_valid;
  grant_t gnt_sel;
  logic   busy;
  logic   lat_zero;
  logic   starve_hit;

  assign busy = (state_q != ARB_IDLE);

  // Data wins a conflict (older instruction) unless fetch has used up its patience.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_sel   = GNT_D;
    if (state_q == ARB_IDLE) begin
      if (bus.d_req && !(bus.if_req && starve_hit)) begin
        gnt_valid = 1'b1;
        gnt_sel   = GNT_D;
      end else if (bus.if_req) begin
        gnt_valid = 1'b1;
        gnt_sel   = GNT_IF;
      end
    end
  end

  arb_lat_counter #(
    .MAX_VAL (MEM_LAT),
    .RST_VAL (0)
  ) u_lat_cnt (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (gnt_valid),
    .load_val_i (LAT_W'(MEM_LAT - 1)),
    .dec_i      (busy),
    .zero_o     (lat_zero)
  );

`ifdef ARB_FAIRNESS_EN
  localparam int unsigned STV_W = cnt_w(STARVE_MAX);

  logic starve_load;
  logic starve_dec;

  // Counts down the data grants fetch may still lose; zero means fetch wins next conflict.
  assign starve_load = !bus.if_req || (gnt_valid && (gnt_sel == GNT_IF));
  assign starve_dec  = gnt_valid && (gnt_sel == GNT_D) && bus.if_req;

  arb_lat_counter #(
    .MAX_VAL (STARVE_MAX),
    .RST_VAL (STARVE_MAX)
  ) u_starve_cnt (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (starve_load),
    .load_val_i (STV_W'(STARVE_MAX)),
    .dec_i      (starve_dec),
    .zero_o     (starve_hit)
  );
`else
  assign starve_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ARB_IDLE;
      d_we_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
    end else begin
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (gnt_valid) begin
            mem_en_q <= 1'b1;
            if (gnt_sel == GNT_D) begin
              state_q     <= ARB_BUSY_D;
              d_we_q      <= bus.d_we;
              mem_we_q    <= bus.d_we;
              mem_addr_q  <= bus.d_addr;
              mem_wdata_q <= bus.d_wdata;
            end else begin
              state_q    <= ARB_BUSY_IF;
              mem_addr_q <= bus.if_addr;
            end
          end
        end
        ARB_BUSY_IF: begin
          if (lat_zero) begin
            if_rdata_q <= bus.mem_rdata;
            if_valid_q <= 1'b1;
            state_q    <= ARB_IDLE;
          end
        end
        ARB_BUSY_D: begin
          if (lat_zero) begin
            if (!d_we_q) begin
              d_rdata_q <= bus.mem_rdata;
            end
            d_valid_q <= 1'b1;
            state_q   <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.stall_if  = bus.if_req & ~if_valid_q;
  assign bus.stall_mem = bus.d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed timing cases plus randomized traffic.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;
`ifdef ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  typedef struct {
    logic [8:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } acc_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MEM_LAT    (MEM_LAT),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory environment: read data appears one cycle after issue (MEM_LAT = 2).
  logic [31:0] mem     [512];
  logic [31:0] ref_mem [512];
  logic [31:0] rd_pipe = '0;
  assign bus.mem_rdata = rd_pipe;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      rd_pipe <= mem[bus.mem_addr];
      if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
    end
  end

  // Reference model: per-port expected completions, in order.
  acc_t        exp_if [$];
  acc_t        exp_d  [$];
  logic [31:0] last_d_read = '0;

  function automatic void push_if(input logic [8:0] a);
    acc_t e;
    e.addr = a; e.we = 1'b0; e.wdata = '0; e.rdata = ref_mem[a];
    exp_if.push_back(e);
  endfunction

  function automatic void push_d(input logic we, input logic [8:0] a, input logic [31:0] wd);
    acc_t e;
    e.addr = a; e.we = we; e.wdata = wd;
    if (we) begin
      ref_mem[a] = wd;
      e.rdata    = last_d_read;
    end else begin
      e.rdata     = ref_mem[a];
      last_d_read = e.rdata;
    end
    exp_d.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: remembers the last issue and checks every completion against the scoreboard.
  logic [8:0]  iss_addr  = '0;
  logic        iss_we    = 1'b0;
  logic [31:0] iss_wdata = '0;
  int          iss_cyc   = -100;
  bit          rec_en    = 1'b0;
  bit          rec_kind [$];
  int          rec_cyc  [$];
  acc_t        mon_e;

  task automatic check_done(input string nm, input acc_t e, input logic [31:0] rdata);
    chk({nm, " rdata"}, rdata, e.rdata);
    chk({nm, " issued addr"}, iss_addr, e.addr);
    chk({nm, " issued we"}, iss_we, e.we);
    if (e.we) chk({nm, " issued wdata"}, iss_wdata, e.wdata);
    chk({nm, " latency"}, cyc - iss_cyc, MEM_LAT);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (bus.mem_en) begin
        iss_addr  = bus.mem_addr;
        iss_we    = bus.mem_we;
        iss_wdata = bus.mem_wdata;
        iss_cyc   = cyc;
      end
      if (bus.if_valid) begin
        if (rec_en) begin rec_kind.push_back(1'b1); rec_cyc.push_back(cyc); end
        if (exp_if.size() == 0) begin
          total++; bad++;
          $display("FAIL if_valid unexpected: got pulse, required none");
        end else begin
          mon_e = exp_if.pop_front();
          check_done("if", mon_e, bus.if_rdata);
        end
      end
      if (bus.d_valid) begin
        if (rec_en) begin rec_kind.push_back(1'b0); rec_cyc.push_back(cyc); end
        if (exp_d.size() == 0) begin
          total++; bad++;
          $display("FAIL d_valid unexpected: got pulse, required none");
        end else begin
          mon_e = exp_d.pop_front();
          check_done("d", mon_e, bus.d_rdata);
        end
      end
    end
  end

  task automatic run_if(input int n, input int gap_max);
    logic [8:0] a;
    int gap, w;
    for (int i = 0; i < n; i++) begin
      a = 9'($urandom_range(0, 255));
      bus.if_addr = a;
      bus.if_req  = 1'b1;
      push_if(a);
      w = 0;
      do begin step(); w++; end while (!bus.if_valid && w < 300);
      total++;
      if (!bus.if_valid) begin
        bad++;
        $display("FAIL if_wait: got no if_valid in %0d cycles, required a completion", w);
        bus.if_req = 1'b0;
        return;
      end
      gap = $urandom_range(0, gap_max);
      if (gap > 0 || i == n - 1) begin
        bus.if_req = 1'b0;
        repeat (gap) step();
      end
    end
  endtask

  task automatic run_d(input int n, input int gap_max);
    logic [8:0]  a;
    logic [31:0] wd;
    logic        we;
    int gap, w;
    for (int i = 0; i < n; i++) begin
      a  = 9'(256 + $urandom_range(0, 255));
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      bus.d_addr  = a;
      bus.d_we    = we;
      bus.d_wdata = wd;
      bus.d_req   = 1'b1;
      push_d(we, a, wd);
      w = 0;
      do begin step(); w++; end while (!bus.d_valid && w < 300);
      total++;
      if (!bus.d_valid) begin
        bad++;
        $display("FAIL d_wait: got no d_valid in %0d cycles, required a completion", w);
        bus.d_req = 1'b0;
        return;
      end
      gap = $urandom_range(0, gap_max);
      if (gap > 0 || i == n - 1) begin
        bus.d_req = 1'b0;
        repeat (gap) step();
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r_if, r_d;
    logic [31:0] prev;
    int          n_win;

    for (int i = 0; i < 512; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[9'h010]     = 32'h0050_0093;
    ref_mem[9'h010] = 32'h0050_0093;

    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req  = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

    // Reset held with random requests: everything registered stays at zero.
    for (int k = 0; k < 4; k++) begin
      r_if = 1'($urandom_range(0, 1));
      r_d  = 1'($urandom_range(0, 1));
      bus.if_req = r_if; bus.d_req = r_d;
      bus.if_addr = 9'($urandom); bus.d_addr = 9'($urandom);
      bus.d_we = 1'($urandom_range(0, 1)); bus.d_wdata = $urandom;
      @(negedge clk);
      chk("rst mem_en", bus.mem_en, 0);
      chk("rst valids", {bus.if_valid, bus.d_valid}, 0);
      chk("rst if_rdata", bus.if_rdata, 0);
      chk("rst d_rdata", bus.d_rdata, 0);
      chk("rst stall_if", bus.stall_if, r_if);
      chk("rst stall_mem", bus.stall_mem, r_d);
      step();
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle mem_en", bus.mem_en, 0);
      step();
    end

    // Single fetch.
    bus.if_addr = 9'h010;
    push_if(9'h010);
    for (int k = 0; k < 6; k++) begin
      bus.if_req = (k < 3);
      @(negedge clk);
      chk("fetch mem_en", bus.mem_en, (k == 1));
      if (k == 1) chk("fetch mem_addr", bus.mem_addr, 9'h010);
      chk("fetch if_valid", bus.if_valid, (k == 3));
      if (k == 3) chk("fetch if_rdata", bus.if_rdata, 32'h0050_0093);
      chk("fetch stall_if", bus.stall_if, (k < 3));
      step();
    end
    repeat (2) step();

    // Simultaneous requests: data first, fetch right after.
    bus.d_addr = 9'h040; bus.d_we = 1'b0; bus.if_addr = 9'h014;
    push_d(1'b0, 9'h040, '0);
    push_if(9'h014);
    for (int k = 0; k < 8; k++) begin
      bus.d_req  = (k < 3);
      bus.if_req = (k < 6);
      @(negedge clk);
      chk("conf mem_en", bus.mem_en, (k == 1 || k == 4));
      if (k == 1) chk("conf first addr", bus.mem_addr, 9'h040);
      if (k == 4) chk("conf second addr", bus.mem_addr, 9'h014);
      chk("conf d_valid", bus.d_valid, (k == 3));
      chk("conf if_valid", bus.if_valid, (k == 6));
      chk("conf stall_if", bus.stall_if, (k < 6));
      chk("conf stall_mem", bus.stall_mem, (k < 3));
      step();
    end
    repeat (2) step();

    // Data write.
    prev = last_d_read;
    bus.d_we = 1'b1; bus.d_addr = 9'h020; bus.d_wdata = 32'hDEAD_BEEF;
    push_d(1'b1, 9'h020, 32'hDEAD_BEEF);
    for (int k = 0; k < 5; k++) begin
      bus.d_req = (k < 3);
      @(negedge clk);
      chk("wr mem_en", bus.mem_en, (k == 1));
      chk("wr mem_we", bus.mem_we, (k == 1));
      if (k == 1) begin
        chk("wr mem_addr", bus.mem_addr, 9'h020);
        chk("wr mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      end
      chk("wr d_valid", bus.d_valid, (k == 3));
      if (k == 3) chk("wr d_rdata kept", bus.d_rdata, prev);
      step();
    end
    bus.d_we = 1'b0;
    repeat (2) step();

    // Reset in the middle of a data read; the request is held across it.
    bus.d_addr = 9'h044;
    push_d(1'b0, 9'h044, '0);
    for (int k = 0; k < 2; k++) begin
      bus.d_req = 1'b1;
      @(negedge clk);
      chk("mid mem_en", bus.mem_en, (k == 1));
      step();
    end
    reset = 1'b0;
    exp_d.delete();
    last_d_read = '0;
    @(negedge clk);
    chk("mid rst d_valid", bus.d_valid, 0);
    chk("mid rst d_rdata", bus.d_rdata, 0);
    chk("mid rst stall_mem", bus.stall_mem, 1);
    step();
    reset = 1'b1;
    push_d(1'b0, 9'h044, '0);
    for (int k = 0; k < 5; k++) begin
      bus.d_req = (k < 3);
      @(negedge clk);
      chk("post rst d_valid", bus.d_valid, (k == 3));
      chk("post rst mem_en", bus.mem_en, (k == 1));
      step();
    end
    repeat (2) step();

    // Both ports saturated: record completion order over a 40-cycle window.
    rec_kind.delete(); rec_cyc.delete();
    n_win = cyc;
    rec_en = 1'b1;
    fork
      run_if(3, 0);
      run_d(14, 0);
    join
    rec_en = 1'b0;
    begin
      int cnt;
      cnt = 0;
      foreach (rec_cyc[j]) if (rec_cyc[j] - n_win < 40) cnt++;
      chk("starve window count", cnt, 13);
      for (int j = 0; j < cnt && j < 13; j++) begin
        chk("starve cycle", rec_cyc[j] - n_win, 3 * (j + 1));
        chk("starve winner is IF", rec_kind[j], FAIR && ((j % (STARVE_MAX + 1)) == STARVE_MAX));
      end
    end
    repeat (3) step();

    // Randomized mixed traffic.
    fork
      run_if(30, 3);
      run_d(30, 3);
    join
    repeat (6) step();
    chk("if scoreboard drained", exp_if.size(), 0);
    chk("d scoreboard drained", exp_d.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency memory between the fetch port (IF stage) and the data port (MEM stage) of the 5-stage pipeline.
- Sequences every access: grants, issues, counts latency, returns data and pulses completion.
- Drives the stall requests the pipeline uses to freeze the PC and the IF/MEM registers while an access is outstanding.

Parameters:
- ADDR_W, 9, memory address width (matches PC_W/DM_ADDRESS).
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from the issue cycle to the cycle mem_rdata is valid. Must be >=1; 1 means same-cycle (combinational) memory.
- STARVE_MAX, 4, consecutive data grants tolerated while if_req waits (fairness feature only).

Ports:
- clk  in  1  global clock
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch access request (level, read-only)
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetch read data
- if_valid  out  1  one-cycle fetch completion pulse
- d_req  in  1  data access request (level)
- d_we  in  1  data write enable
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  data write data
- d_rdata  out  DATA_W  data read data
- d_valid  out  1  one-cycle data completion pulse
- mem_en  out  1  memory access strobe (issue cycle)
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid in cycle issue+MEM_LAT-1
- stall_if  out  1  if_req & ~if_valid
- stall_mem  out  1  d_req & ~d_valid

Behaviour:
- Reset (reset=0, async): state IDLE, latency counter 0, all registered outputs 0 (mem_*, if_rdata, d_rdata, if_valid, d_valid). Stalls follow their equations.
- States:
  - IDLE: no access in flight.
  - BUSY_IF: fetch in flight.
  - BUSY_D: data in flight.
- IDLE transitions:
  - Samples requests every cycle.
  - d_req only -> BUSY_D. if_req only -> BUSY_IF. Both -> BUSY_D (data priority; the MEM-stage instruction is older).
  - Neither -> stay IDLE.
  - On the grant edge, address, we and wdata of the winner are registered.
- Issue: first BUSY cycle has mem_en=1, mem_we=d_we (0 for IF), registered mem_addr/mem_wdata. mem_en/mem_we are 0 in all other cycles.
- Latency counter: loads MEM_LAT-1 on grant and decrements each BUSY cycle.
  - At count 0, mem_rdata is registered into the winner's rdata and the FSM returns to IDLE.
  - The winner's valid pulses high for exactly the next cycle.
- Latency: request seen in IDLE cycle N -> mem_en in cycle N+1 -> valid in cycle N+MEM_LAT+1.
- Request rule:
  - A requester holds req until its valid cycle.
  - Req still high during its own valid cycle is a NEW request. The requester deasserts combinationally in that cycle if it has no further access.
  - This gives back-to-back accesses with no bubble.
- Writes: d_valid pulses at the same latency as reads. d_rdata is unchanged on writes.
- Requests arriving while BUSY are held (stall) until the next IDLE decision. Requests are never dropped.
- Address/data inputs may change while BUSY; only the values registered at grant are used.
- Reset mid-access: state returns to IDLE immediately and the in-flight valid is never pulsed. The stalled requester re-arbitrates after release.
- Counter width: $clog2(MEM_LAT+1).

Optional Feature:
- Macro ARB_FAIRNESS_EN.
- Defined:
  - A starvation counter increments on each data grant made while if_req=1.
  - When it equals STARVE_MAX, the next simultaneous conflict is granted to IF.
  - The counter clears on any IF grant or when if_req=0.
- Undefined: strict data priority; IF may wait indefinitely while d_req stays high.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum arb_state_t {ARB_IDLE, ARB_BUSY_IF, ARB_BUSY_D}
  - typedef enum grant_t {GNT_IF, GNT_D}
  - localparam defaults for ADDR_W/DATA_W.
- Sub-module arb_lat_counter: load/decrement/zero-flag down counter parameterised by MEM_LAT. It is reused for the starvation counter.

Test Plan:
- Reset low with random inputs -> mem_en=0, if_valid=d_valid=0, rdata=0. Release with no requests -> mem_en stays 0 for 10 cycles.
- if_req cycle 0, if_addr 0x010, memory returns 0x00500093 (MEM_LAT=2) -> mem_en/addr 0x010 in cycle 1, if_valid=1 with if_rdata 0x00500093 in cycle 3 only, stall_if=1 in cycles 0-2.
- if_req and d_req (read 0x040) both in cycle 0 -> data issued cycle 1, d_valid cycle 3. IF issued cycle 4, if_valid cycle 6. stall_if high cycles 0-5.
- d_req write, d_addr 0x020, d_wdata 0xDEADBEEF -> cycle 1 mem_en=mem_we=1, mem_addr 0x020, mem_wdata 0xDEADBEEF. d_valid cycle 3, d_rdata unchanged.
- reset pulsed low in cycle 2 of a data read -> d_valid never asserts, state IDLE. After release d_req re-held -> d_valid 3 cycles after release.
- if_req and d_req held continuously for 40 cycles, STARVE_MAX=4 -> with ARB_FAIRNESS_EN, one IF grant after every 4 data grants. Without it, if_valid stays 0.
